// File: rtl/edge_pkg.sv
// Shared types and helpers for the multi-channel edge event monitor.
package edge_pkg;

    typedef enum logic [1:0] {
        EM_OFF  = 2'b00,
        EM_RISE = 2'b01,
        EM_FALL = 2'b10,
        EM_BOTH = 2'b11
    } edge_mode_e;

    // Saturating add on a 32-bit carrier; the caller passes its own all-ones limit.
    function automatic logic [31:0] sat_add(input logic [31:0] base,
                                            input logic [31:0] inc,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, base} + {1'b0, inc};
        if (sum > {1'b0, max_val})
            return max_val;
        else
            return sum[31:0];
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser chain, stability filter and registered edge pulses.
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CW = $clog2(FILT_CYCLES) + 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_filt;
    logic                   r_filt_d1;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync     <= '0;
            r_cnt      <= '0;
            r_filt     <= 1'b0;
            r_filt_d1  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            // A new level is accepted only after FILT_CYCLES consecutive sync samples.
            if (w_sync == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILT_CYCLES - 1)) begin
                r_filt <= w_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_filt_d1  <= r_filt;
            rise_pulse <= r_filt & ~r_filt_d1;
            fall_pulse <= ~r_filt & r_filt_d1;
        end
    end

endmodule

// File: rtl/edge_event_monitor.sv
// Multi-channel edge monitor: per-channel filtered pulses, sticky pending flags
// and a shared saturating count of mode-qualified events.
module edge_event_monitor
    import edge_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       sig_in,
    input  logic [N_CH-1:0][1:0]  edge_mode,
    input  logic [N_CH-1:0]       clr_pending,
    input  logic                  cnt_clr,
    output logic [N_CH-1:0]       rise_pulse,
    output logic [N_CH-1:0]       fall_pulse,
    output logic [N_CH-1:0]       both_pulse,
    output logic [N_CH-1:0]       pending,
    output logic                  event_any,
    output logic [CNT_W-1:0]      event_cnt
);

    localparam int          PC_W    = $clog2(N_CH + 1);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF >> (32 - CNT_W);

    logic [N_CH-1:0]  w_hit;
    logic [PC_W-1:0]  w_pop;
    logic [CNT_W-1:0] w_base;
    logic [N_CH-1:0]  r_pending;
    logic [CNT_W-1:0] r_event_cnt;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        edge_mode_e w_mode;
        assign w_mode = edge_mode_e'(edge_mode[i]);

        edge_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_CYCLES(FILT_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .sig_in    (sig_in[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i])
        );

        // Mode is looked at only alongside a pulse, so mode changes alone never count.
        assign w_hit[i] = (rise_pulse[i] & (w_mode == EM_RISE || w_mode == EM_BOTH)) |
                          (fall_pulse[i] & (w_mode == EM_FALL || w_mode == EM_BOTH));
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_CH; i++)
            w_pop = w_pop + PC_W'(w_hit[i]);
    end

    assign w_base = cnt_clr ? '0 : r_event_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending   <= '0;
            r_event_cnt <= '0;
        end else begin
            // Set has priority over a same-cycle clear.
            r_pending   <= (r_pending & ~clr_pending) | w_hit;
            r_event_cnt <= CNT_W'(sat_add(32'(w_base), 32'(w_pop), CNT_MAX));
        end
    end

    assign both_pulse = rise_pulse | fall_pulse;
    assign pending    = r_pending;
    assign event_any  = |r_pending;
    assign event_cnt  = r_event_cnt;

endmodule
